regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single write port of the 8x16 register file between two writeback requesters (req0: ALU result, req1: load/external data).
- Arbitration is round-robin with a valid/ready handshake per requester.
- The granted write is registered and driven to the register file's write port one cycle later as a single-cycle write strobe.
- A saturating counter reports cycles where both requesters contend, for performance visibility.

Parameters:
DATA_W, 16, width of write data
ADDR_W, 3, register index width (2**ADDR_W registers)
CNT_W, 8, width of the contention counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
port_busy  input  1  register file write port unavailable this cycle; no grant issued
req0_valid  input  1  requester 0 has a write pending
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 has a write pending
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 write accepted this cycle
wr_en  output  1  write strobe to register file, one cycle wide
wr_addr  output  ADDR_W  register file write address
wr_data  output  DATA_W  register file write data
last_grant  output  1  index of the requester granted most recently
conflict_cnt  output  CNT_W  saturating count of cycles with both valid and port_busy low

Behaviour:
Reset (rst high at clk edge):
- wr_en=0, wr_addr=0, wr_data=0.
- last_grant=1, so req0 has first priority.
- conflict_cnt=0.
- A write accepted in the cycle before reset is dropped: wr_en=0 after the reset edge.

Grant (combinational, same cycle):
- port_busy=1: both ready=0.
- Else, only one valid: that requester gets ready=1.
- Else, both valid: the requester != last_grant gets ready=1, the other gets ready=0.
- Else: both ready=0.
- At most one ready is high per cycle. ready never depends on any requester's ready.

Handshake:
- A transfer occurs when valid && ready.
- A requester holds valid, addr and data stable until accepted.
- Dropping valid before acceptance is illegal; the bench asserts this.

Write stage (registered):
- Transfer in cycle N: in cycle N+1, wr_en=1 and wr_addr/wr_data equal the accepted request's addr/data.
- No transfer in cycle N: wr_en=0 in N+1, and wr_addr/wr_data hold their last values.
- Latency is exactly 1 cycle. Throughput is 1 write per cycle.

last_grant: updated to the granted index on every transfer, otherwise held.

Same-address writes: when both requesters target the same register, the writes occur in grant order on consecutive cycles, so the later grant's data persists.

conflict_cnt:
- Increments by 1 when req0_valid && req1_valid && !port_busy.
- Saturates at 2**CNT_W-1 and does not wrap.

Optional Feature:
Macro REGFILE_R0_ZERO_EN:
- When defined, register 0 is hard-wired zero.
- A request with addr 0 is still granted and handshaken normally (ready=1, last_grant updated).
- The following cycle has wr_en=0 and wr_addr/wr_data unchanged.
When undefined:
- Writes to addr 0 behave like any other address.

Test Plan:
- Reset, then req0 valid, addr=2, data=16'h1234 -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=2, wr_data=16'h1234; following cycle wr_en=0.
- Both valid every cycle: req0 (3, 16'hAAAA) and req1 (5, 16'h5555) -> grants alternate req0, req1, req0 ...; wr_en stays high continuously; conflict_cnt increments once per contended cycle.
- port_busy=1 for 3 cycles with req1 valid (addr 7, data 16'hBEEF) -> req1_ready=0 and wr_en=0 for those cycles; req1 granted in the first cycle with port_busy=0; write visible next cycle.
- Both valid targeting addr 4 (req0 data 16'h0001, req1 data 16'h0002) after last_grant=0 -> req1 written first, then req0; final register 4 = 16'h0001.
- rst asserted the cycle after a transfer -> wr_en=0 after reset edge, all outputs at reset values, last_grant=1, conflict_cnt=0.
- 300 contended cycles with CNT_W=8 -> conflict_cnt=255 and holds; with REGFILE_R0_ZERO_EN defined, req0 addr=0 data=16'hFFFF -> req0_ready=1, wr_en=0 next cycle.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two writeback requesters.
// Latency: one cycle from the accepting handshake to the wr_en strobe; one write per cycle.
// Backpressure: port_busy or losing arbitration holds ready low; requesters keep valid/addr/data until accepted.
// Optional build macro REGFILE_R0_ZERO_EN: register 0 is hard-wired zero, so writes to it are accepted but never strobed.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              port_busy,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              last_grant,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              xfer0;
    logic              xfer1;
    logic              xfer;
    logic              commit;
    logic              contend;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grant: a lone requester wins outright; under contention the one not granted last time wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!port_busy) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign xfer0    = req0_valid && req0_ready;
    assign xfer1    = req1_valid && req1_ready;
    assign xfer     = xfer0 || xfer1;
    assign sel_addr = xfer1 ? req1_addr : req0_addr;
    assign sel_data = xfer1 ? req1_data : req0_data;
    assign contend  = req0_valid && req1_valid && !port_busy;

`ifdef REGFILE_R0_ZERO_EN
    // Register 0 reads as zero, so a write to it is handshaken but never reaches the port.
    assign commit = xfer && (sel_addr != '0);
`else
    assign commit = xfer;
`endif

    // Write stage: strobe for one cycle after an accepted write; address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_grant <= 1'b1;
        end else begin
            wr_en <= commit;
            if (commit) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
            if (xfer) begin
                last_grant <= xfer1;
            end
        end
    end

    // Contention counter: counts cycles where both requesters compete for a free port, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (contend && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter with a scoreboard of expected register-file writes.
// A reference model predicts grants, the contention count and the write sequence; a monitor checks writes.
// Also keeps a shadow register file on each side and compares them at the end.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              port_busy = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              last_grant;
    logic [CNT_W-1:0]  conflict_cnt;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .port_busy(port_busy),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_grant(last_grant), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    logic [DATA_W-1:0] rf_ref [8];
    logic [DATA_W-1:0] rf_dut [8];

    // stimulus controls, written by the main sequence right after a rising edge
    int                rst_req = 1;
    int                p0 = 0, p1 = 0, pbusy = 0;
    bit                fix0 = 0, fix1 = 0;
    logic [ADDR_W-1:0] fa0 = '0, fa1 = '0;
    logic [DATA_W-1:0] fd0 = '0, fd1 = '0;
    bit                acc0 = 0, acc1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester/driver: holds a pending request until the handshake, then draws a new one.
    always @(posedge clk) begin
        #1;
        rst       = (rst_req != 0);
        port_busy = ($urandom_range(99) < pbusy);
        if (rst) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end else begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(99) < p0);
                req0_addr  = fix0 ? fa0 : ADDR_W'($urandom_range(7));
                req0_data  = fix0 ? fd0 : DATA_W'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(99) < p1);
                req1_addr  = fix1 ? fa1 : ADDR_W'($urandom_range(7));
                req1_data  = fix1 ? fd1 : DATA_W'($urandom);
            end
        end
    end

    // Reference model: grant rules, contention count and expected write sequence.
    bit                m_armed = 0;
    int                m_lg = 1;
    int                m_cnt = 0;
    bit                pv0 = 0, pv1 = 0, pr = 1;
    logic [ADDR_W-1:0] pa0, pa1;
    logic [DATA_W-1:0] pd0, pd1;
    always @(negedge clk) begin
        bit e0, e1, both;
        both = req0_valid && req1_valid;
        e0 = !port_busy && req0_valid && (!req1_valid || m_lg == 1);
        e1 = !port_busy && req1_valid && (!req0_valid || m_lg == 0);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (m_armed) begin
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("last_grant", 32'(last_grant), 32'(m_lg));
            chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
            if (!rst && !pr) begin
                assert (!(pv0 && !acc0) || (req0_valid && req0_addr == pa0 && req0_data == pd0))
                    else $error("FAIL hold0: requester 0 changed a pending request");
                assert (!(pv1 && !acc1) || (req1_valid && req1_addr == pa1 && req1_data == pd1))
                    else $error("FAIL hold1: requester 1 changed a pending request");
            end
        end
        pv0 = req0_valid && !acc0; pa0 = req0_addr; pd0 = req0_data;
        pv1 = req1_valid && !acc1; pa1 = req1_addr; pd1 = req1_data;
        pr  = rst;
        if (rst) begin
            m_lg    = 1;
            m_cnt   = 0;
            m_armed = 1;
        end else begin
            if (e0 || e1) begin
                exp_t e;
                e.addr = e1 ? req1_addr : req0_addr;
                e.data = e1 ? req1_data : req0_data;
                e.cyc  = cyc + 1;
                m_lg   = e1 ? 1 : 0;
`ifdef REGFILE_R0_ZERO_EN
                if (e.addr != 0) begin
                    exp_q.push_back(e);
                    rf_ref[e.addr] = e.data;
                end
`else
                exp_q.push_back(e);
                rf_ref[e.addr] = e.data;
`endif
            end
            if (both && !port_busy && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    // Monitor: pops the scoreboard on every write strobe and checks held values otherwise.
    bit                mon_armed = 0;
    logic [ADDR_W-1:0] h_addr = '0;
    logic [DATA_W-1:0] h_data = '0;
    always @(negedge clk) begin
        if (mon_armed) begin
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wr_en_unexpected", 32'(wr_en), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                    h_addr = e.addr;
                    h_data = e.data;
                    rf_dut[wr_addr] = wr_data;
                end
            end else begin
                chk("wr_en", 32'(wr_en), 32'((exp_q.size() > 0 && exp_q[0].cyc == cyc) ? 1 : 0));
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) void'(exp_q.pop_front());
                chk("wr_addr_hold", 32'(wr_addr), 32'(h_addr));
                chk("wr_data_hold", 32'(wr_data), 32'(h_data));
            end
        end
        if (rst) begin
            h_addr    = '0;
            h_data    = '0;
            mon_armed = 1;
        end
    end

    task automatic phase(input int n, input int a0, input int a1, input int ab);
        p0 = a0; p1 = a1; pbusy = ab;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf_ref[i] = '0;
            rf_dut[i] = '0;
        end
        rst_req = 1;
        repeat (3) @(posedge clk);
        rst_req = 0;
        phase(3, 0, 0, 0);
        // single write from requester 0
        fix0 = 1; fa0 = 3'd2; fd0 = 16'h1234;
        phase(1, 100, 0, 0);
        phase(3, 0, 0, 0);
        // continuous contention with alternating grants
        fa0 = 3'd3; fd0 = 16'hAAAA; fix1 = 1; fa1 = 3'd5; fd1 = 16'h5555;
        phase(20, 100, 100, 0);
        phase(3, 0, 0, 0);
        // requester 1 stalled by a busy port
        fa1 = 3'd7; fd1 = 16'hBEEF;
        phase(3, 0, 100, 100);
        phase(1, 0, 0, 0);
        phase(3, 0, 0, 0);
        // same-address race after req0 was granted last
        fa0 = 3'd4; fd0 = 16'h0001;
        phase(1, 100, 0, 0);
        phase(2, 0, 0, 0);
        fa1 = 3'd4; fd1 = 16'h0002;
        phase(1, 100, 100, 0);
        phase(3, 0, 0, 0);
        chk("rf4_order", 32'(rf_dut[4]), 32'h0001);
        // reset in the cycle after a transfer
        phase(4, 100, 50, 0);
        rst_req = 1;
        phase(1, 0, 0, 0);
        rst_req = 0;
        phase(3, 0, 0, 0);
        // register 0 write
        fa0 = 3'd0; fd0 = 16'hFFFF;
        phase(1, 100, 0, 0);
        phase(3, 0, 0, 0);
        // random traffic
        fix0 = 0; fix1 = 0;
        phase(1500, 60, 60, 20);
        phase(500, 90, 90, 5);
        // saturation of the contention counter from zero
        rst_req = 1;
        phase(1, 0, 0, 0);
        rst_req = 0;
        phase(300, 100, 100, 0);
        phase(20, 100, 100, 0);
        phase(5, 0, 0, 0);
        chk("cnt_saturated", 32'(conflict_cnt), 32'(CNT_MAX));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rf[%0d]", i), 32'(rf_dut[i]), 32'(rf_ref[i]));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
